// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions for the frame checker and the transmit-side generator.
// Holds widths, polynomial/seed defaults, the checker state type and a bit-step helper.
package crc_pkg;

  localparam int         CRC_W     = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic {COLLECT, DONE} state_t;

  // One MSB-first LFSR step: feedback is the outgoing MSB xored with the incoming bit.
  function automatic logic [CRC_W-1:0] crc8_next_bit(input logic [CRC_W-1:0] crc,
                                                     input logic             b,
                                                     input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/crc_frame_checker_if.sv
// Stream-in / verdict-out bundle of the CRC frame checker.
// The checker connects through the slave modport, the byte source/consumer through master.
interface crc_frame_checker_if #(
  parameter int PAYLOAD_BYTES = 10
);
  logic                         in_valid;
  logic                         in_ready;
  logic [7:0]                   in_byte;
  logic                         in_abort;
  logic                         out_valid;
  logic                         out_ready;
  logic [0:8*PAYLOAD_BYTES-1]   out_data;
  logic                         out_crc_ok;
  logic [7:0]                   out_rx_crc;
  logic [7:0]                   out_calc_crc;
  logic [7:0]                   ok_count;
  logic [7:0]                   bad_count;

  modport master (
    output in_valid, in_byte, in_abort, out_ready,
    input  in_ready, out_valid, out_data, out_crc_ok, out_rx_crc, out_calc_crc,
           ok_count, bad_count
  );

  modport slave (
    input  in_valid, in_byte, in_abort, out_ready,
    output in_ready, out_valid, out_data, out_crc_ok, out_rx_crc, out_calc_crc,
           ok_count, bad_count
  );
endinterface

// File: rtl/crc8_update.sv
// Combinational CRC-8 byte update, MSB first, no reflection.
// Also instantiated by the transmit-side generator, so keep it free of state.
module crc8_update
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      c = crc8_next_bit(c, byte_in[i], POLY);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC-8 frame checker: collects PAYLOAD_BYTES bytes plus a CRC byte,
// then holds payload and verdict until the consumer takes them.
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 10,
  parameter logic [7:0] POLY          = CRC8_POLY,
  parameter logic [7:0] INIT          = CRC8_INIT
) (
  input  logic               clk,
  input  logic               rst,
  crc_frame_checker_if.slave bus
);

  localparam int               CNT_W  = $clog2(PAYLOAD_BYTES + 1);
  localparam int               DATA_W = 8 * PAYLOAD_BYTES;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PAYLOAD_BYTES);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]          crc_q, crc_d;
  logic [0:DATA_W-1]   payload_q, payload_d;
  logic [0:DATA_W-1]   out_data_q, out_data_d;
  logic                out_crc_ok_q, out_crc_ok_d;
  logic [7:0]          out_rx_crc_q, out_rx_crc_d;
  logic [7:0]          out_calc_crc_q, out_calc_crc_d;
  logic [7:0]          ok_count_q, ok_count_d;
  logic [7:0]          bad_count_q, bad_count_d;
  logic [7:0]          crc_next;

  crc8_update #(.POLY(POLY)) u_crc (
    .crc_in  (crc_q),
    .byte_in (bus.in_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    crc_d          = crc_q;
    payload_d      = payload_q;
    out_data_d     = out_data_q;
    out_crc_ok_d   = out_crc_ok_q;
    out_rx_crc_d   = out_rx_crc_q;
    out_calc_crc_d = out_calc_crc_q;
    ok_count_d     = ok_count_q;
    bad_count_d    = bad_count_q;

    case (state_q)
      COLLECT: begin
        // Abort wins over a byte offered in the same cycle.
        if (bus.in_abort) begin
          byte_cnt_d = '0;
          crc_d      = INIT;
        end else if (bus.in_valid) begin
          if (byte_cnt_q < LAST) begin
            // Shifting in at the tail leaves byte 0 at [0:7] once the frame is complete.
            payload_d  = {payload_q[8:DATA_W-1], bus.in_byte};
            crc_d      = crc_next;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end else begin
            out_data_d     = payload_q;
            out_rx_crc_d   = bus.in_byte;
            out_calc_crc_d = crc_q;
            out_crc_ok_d   = (bus.in_byte == crc_q);
            if (bus.in_byte == crc_q) begin
              if (ok_count_q != 8'hFF) ok_count_d = ok_count_q + 8'd1;
            end else begin
              if (bad_count_q != 8'hFF) bad_count_d = bad_count_q + 8'd1;
            end
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d    = COLLECT;
          byte_cnt_d = '0;
          crc_d      = INIT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= COLLECT;
      byte_cnt_q     <= '0;
      crc_q          <= INIT;
      payload_q      <= '0;
      out_data_q     <= '0;
      out_crc_ok_q   <= 1'b0;
      out_rx_crc_q   <= 8'h00;
      out_calc_crc_q <= 8'h00;
      ok_count_q     <= 8'h00;
      bad_count_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      crc_q          <= crc_d;
      payload_q      <= payload_d;
      out_data_q     <= out_data_d;
      out_crc_ok_q   <= out_crc_ok_d;
      out_rx_crc_q   <= out_rx_crc_d;
      out_calc_crc_q <= out_calc_crc_d;
      ok_count_q     <= ok_count_d;
      bad_count_q    <= bad_count_d;
    end
  end

  assign bus.in_ready     = (state_q == COLLECT);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_data     = out_data_q;
  assign bus.out_crc_ok   = out_crc_ok_q;
  assign bus.out_rx_crc   = out_rx_crc_q;
  assign bus.out_calc_crc = out_calc_crc_q;
  assign bus.ok_count     = ok_count_q;
  assign bus.bad_count    = bad_count_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker: directed frames, aborts, back-pressure,
// reset mid-frame and counter saturation, against a polynomial long-division model.
module tb_crc_frame_checker;
  localparam int PB = 10;

  typedef logic [7:0] pl_t [PB];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crc_frame_checker_if #(.PAYLOAD_BYTES(PB)) bus();

  crc_frame_checker #(.PAYLOAD_BYTES(PB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int ok_exp   = 0;
  int bad_exp  = 0;
  int frame_no = 0;

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, bit by bit over the whole message.
  function automatic logic [7:0] ref_crc(input pl_t pl);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < PB; i++) begin
      for (int k = 7; k >= 0; k--) begin
        r = {r[7:0], pl[i][k]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    for (int k = 0; k < 8; k++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(posedge clk);
  endtask

  task automatic run_frame(input pl_t pl, input logic [7:0] crc, input int hold,
                           output logic [7:0] calc_obs, output logic [0:8*PB-1] data_obs);
    logic [7:0]      exp_calc;
    logic            exp_ok;
    logic [0:8*PB-1] exp_data;
    for (int i = 0; i < PB; i++) put(pl[i]);
    @(negedge clk);
    chk("pre_valid", 128'(bus.out_valid), 128'(0));
    bus.in_valid = 1'b1;
    bus.in_byte  = crc;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;

    exp_calc = ref_crc(pl);
    exp_ok   = (crc == exp_calc);
    for (int i = 0; i < PB; i++) exp_data[8*i +: 8] = pl[i];
    if (exp_ok) begin
      if (ok_exp < 255) ok_exp++;
    end else begin
      if (bad_exp < 255) bad_exp++;
    end

    chk("out_valid", 128'(bus.out_valid), 128'(1));
    chk("in_ready_done", 128'(bus.in_ready), 128'(0));
    chk("crc_ok", 128'(bus.out_crc_ok), 128'(exp_ok));
    chk("rx_crc", 128'(bus.out_rx_crc), 128'(crc));
    chk("calc_crc", 128'(bus.out_calc_crc), 128'(exp_calc));
    chk("out_data", 128'(bus.out_data), 128'(exp_data));
    chk("ok_count", 128'(bus.ok_count), 128'(ok_exp));
    chk("bad_count", 128'(bus.bad_count), 128'(bad_exp));
    calc_obs = bus.out_calc_crc;
    data_obs = bus.out_data;
    $display("frame %0d: rx=%02h calc=%02h ok=%0b ok_cnt=%0d bad_cnt=%0d hold=%0d",
             frame_no, bus.out_rx_crc, bus.out_calc_crc, bus.out_crc_ok,
             bus.ok_count, bus.bad_count, hold);
    frame_no++;

    // Bytes offered while the verdict waits must be ignored.
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
      chk("hold_calc", 128'(bus.out_calc_crc), 128'(exp_calc));
      chk("hold_data", 128'(bus.out_data), 128'(exp_data));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_valid", 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    pl_t             pl;
    pl_t             pl2;
    logic [7:0]      calc;
    logic [0:8*PB-1] data;
    logic [7:0]      c;

    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_abort  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    chk("rst_crc_ok", 128'(bus.out_crc_ok), 128'(0));
    chk("rst_rx_crc", 128'(bus.out_rx_crc), 128'(0));
    chk("rst_calc_crc", 128'(bus.out_calc_crc), 128'(0));
    chk("rst_ok_count", 128'(bus.ok_count), 128'(0));
    chk("rst_bad_count", 128'(bus.bad_count), 128'(0));
    rst = 1'b0;

    // 1: all-zero frame
    for (int i = 0; i < PB; i++) pl[i] = 8'h00;
    run_frame(pl, 8'h00, 0, calc, data);
    chk("t1_calc", 128'(calc), 128'(8'h00));
    chk("t1_ok_count", 128'(bus.ok_count), 128'(1));

    // 2: last byte 01 -> CRC 07
    pl2 = pl;
    pl2[PB-1] = 8'h01;
    run_frame(pl2, 8'h07, 0, calc, data);
    chk("t2_calc", 128'(calc), 128'(8'h07));
    chk("t2_last_byte", 128'(data[72:79]), 128'(8'h01));

    // 3: wrong CRC
    run_frame(pl2, 8'h08, 0, calc, data);
    chk("t3_bad_count", 128'(bus.bad_count), 128'(1));

    // 4: back-pressure for 5 cycles
    run_frame(pl2, 8'h07, 5, calc, data);

    // 5: abort after four bytes, with a byte offered alongside
    for (int i = 0; i < 4; i++) put(8'($urandom));
    @(negedge clk);
    bus.in_abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.in_abort = 1'b0;
    bus.in_valid = 1'b0;
    run_frame(pl2, 8'h07, 0, calc, data);
    chk("t5_calc", 128'(calc), 128'(8'h07));

    // Random frames, roughly half with a correct CRC
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < PB; i++) pl[i] = 8'($urandom);
      c = ref_crc(pl);
      if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
      run_frame(pl, c, $urandom_range(0, 3), calc, data);
    end

    // 6: reset at byte 6 of a frame
    for (int i = 0; i < 6; i++) put(8'($urandom));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_out_data", 128'(bus.out_data), 128'(0));
    chk("mid_rst_crc_ok", 128'(bus.out_crc_ok), 128'(0));
    chk("mid_rst_rx_crc", 128'(bus.out_rx_crc), 128'(0));
    chk("mid_rst_calc_crc", 128'(bus.out_calc_crc), 128'(0));
    chk("mid_rst_ok_count", 128'(bus.ok_count), 128'(0));
    chk("mid_rst_bad_count", 128'(bus.bad_count), 128'(0));
    ok_exp  = 0;
    bad_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(pl2, 8'h07, 0, calc, data);
    chk("t6_calc", 128'(calc), 128'(8'h07));

    // 300 bad frames -> bad_count saturates
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < PB; i++) pl[i] = 8'($urandom);
      c = ref_crc(pl) ^ 8'($urandom_range(1, 255));
      run_frame(pl, c, 0, calc, data);
    end
    chk("sat_bad_count", 128'(bus.bad_count), 128'(8'hFF));
    chk("sat_ok_count", 128'(bus.ok_count), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
